// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register slave and its pin synchroniser.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD,
        IGNORE
    } state_t;

    localparam int CMD_RW_BIT  = 7;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings sclk, CS and MOSI into the clk domain and flags sclk/CS edges.
module spi_pin_sync
    import spi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_level,
    output logic cs_rise,
    output logic cs_fall,
    output logic mosi_level
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    // CS resets as if asserted so a CS held low through reset never looks like a new frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise  =  sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall  = ~sclk_sync[SYNC_STAGES-1] &  sclk_prev;
    assign cs_level   =  cs_sync[SYNC_STAGES-1];
    assign cs_rise    =  cs_sync[SYNC_STAGES-1] & ~cs_prev;
    assign cs_fall    = ~cs_sync[SYNC_STAGES-1] &  cs_prev;
    assign mosi_level =  mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// Addressed SPI register slave: command/address/data frames read and write a register bank,
// with the SPI pins oversampled in the clk domain.
module spi_reg_slave
    import spi_pkg::*;
#(
    parameter int         NUM_REGS  = 8,
    parameter int         ADDR_W    = 3,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic                  CPOL,
    input  logic                  CPHA,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  frame_err
);

    state_t            state;
    state_t            state_next;
    logic [7:0]        regs [NUM_REGS];
    logic [2:0]        bit_cnt;
    logic [6:0]        shift_in;
    logic [7:0]        shift_out;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              cpol_q;
    logic              cpha_q;

    logic sclk_rise, sclk_fall, cs_level, cs_rise, cs_fall, mosi_level;
    logic active, lead_edge, trail_edge, sample_edge, shift_edge;
    logic byte_done, cmd_bad, cmd_read, abort;
    logic reg_we, load_rd, err_set;
    logic [7:0] rx_byte;

    spi_pin_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (CS),
        .mosi       (MOSI),
        .sclk_rise  (sclk_rise),
        .sclk_fall  (sclk_fall),
        .cs_level   (cs_level),
        .cs_rise    (cs_rise),
        .cs_fall    (cs_fall),
        .mosi_level (mosi_level)
    );

    assign active      = (state != IDLE);
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = active && (cpha_q ? trail_edge : lead_edge);
    assign shift_edge  = active && (cpha_q ? lead_edge : trail_edge);
    assign byte_done   = sample_edge && (bit_cnt == 3'd7);
    assign rx_byte     = {shift_in, mosi_level};
    assign cmd_bad     = int'(rx_byte[6:0]) >= NUM_REGS;
    assign cmd_read    = rx_byte[CMD_RW_BIT];
    assign abort       = cs_rise && (bit_cnt != 3'd0) && !byte_done;
    assign rd_addr     = (state == CMD) ? rx_byte[ADDR_W-1:0] : ADDR_W'(addr + 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // A byte completing in the same clk as CS rising is still decoded before returning to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cs_fall) state_next = CMD;
            CMD: begin
                if (cs_rise)        state_next = IDLE;
                else if (byte_done) state_next = cmd_bad ? IGNORE : (cmd_read ? RD : WR);
            end
            default: if (cs_rise) state_next = IDLE;
        endcase
    end

    always_comb begin
        MISO    = 1'b0;
        reg_we  = 1'b0;
        load_rd = 1'b0;
        err_set = 1'b0;
        case (state)
            CMD: begin
                load_rd = byte_done && !cmd_bad && cmd_read;
                err_set = (byte_done && cmd_bad) || abort;
            end
            WR: begin
                reg_we  = byte_done;
                err_set = abort;
            end
            RD: begin
                MISO    = shift_out[7];
                load_rd = byte_done;
                err_set = abort;
            end
            default: ;
        endcase
    end

    // The first shift edge of each byte is skipped: bit 7 is already on MISO from the load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            shift_out <= 8'd0;
            addr      <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= reg_we;
            frame_err <= err_set;
            if (cs_level) begin
                cpol_q <= CPOL;
                cpha_q <= CPHA;
            end
            if (state == IDLE)    bit_cnt <= 3'd0;
            else if (sample_edge) bit_cnt <= bit_cnt + 3'd1;
            if (sample_edge) shift_in <= rx_byte[6:0];
            if (state == CMD && byte_done)
                addr <= rx_byte[ADDR_W-1:0];
            else if ((state == WR || state == RD) && byte_done)
                addr <= ADDR_W'(addr + 1'b1);
            if (load_rd)
                shift_out <= regs[rd_addr];
            else if (shift_edge && bit_cnt != 3'd0)
                shift_out <= {shift_out[6:0], 1'b0};
            if (reg_we) wr_addr <= addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else if (reg_we) begin
            regs[addr] <= rx_byte;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_out[8*g +: 8] = regs[g];
    end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- SPI responder that decodes command/address/data frames from the team's SPI master and exposes an 8-entry × 8-bit register bank to system logic.
- Sits on the slave end of the sclk/MOSI/MISO/CS bus and runs entirely in the system clk domain, oversampling the SPI pins.
- Complements the raw byte-level slave with addressed reads and writes, address auto-increment and write strobes.

Parameters:
- NUM_REGS, 8, number of registers; power of two, 2..128.
- ADDR_W, 3, log2(NUM_REGS).
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master, asynchronous to clk.
- CS  in  1  chip select, active-low.
- MOSI  in  1  serial data from master, MSB first.
- MISO  out  1  serial data to master, MSB first.
- CPOL  in  1  SPI clock idle level; quasi-static, sampled only while CS high.
- CPHA  in  1  SPI clock phase; quasi-static, sampled only while CS high.
- reg_out  out  8*NUM_REGS  flattened register bank; reg i at bits [8i+7:8i].
- wr_strobe  out  1  one-clk pulse when a register is written.
- wr_addr  out  ADDR_W  address of the last write; valid with wr_strobe.
- frame_err  out  1  one-clk pulse when CS rises mid-byte or the command address is out of range.

Behaviour:
- Reset (rst=0, async): all registers = RESET_VAL, MISO=0, wr_strobe=0, wr_addr=0, frame_err=0, FSM=IDLE, bit counter=0.
- Synchronisers: sclk, CS and MOSI each pass through 2 flops. Edges are detected on the synchronised sclk. Requirement: f_sclk ≤ f_clk/8.
- Edge roles:
  - leading edge = sclk leaves the CPOL level; trailing edge = sclk returns to it.
  - CPHA=0: sample on leading, shift MISO on trailing; the first MISO bit is driven within 1 clk of synchronised CS falling.
  - CPHA=1: shift on leading, sample on trailing.
- Bytes are MSB first; a 3-bit counter counts sample edges, and a byte completes on the 8th sample edge.
- Frame format:
  - byte0 = command: bit7 R/W (1=read), bits[6:0] = start address.
  - Following bytes are data; the address auto-increments after each data byte and wraps from NUM_REGS-1 to 0.
- FSM states:
  - IDLE: CS high. Entering on CS falling → CMD, with the counter cleared.
  - CMD: after 8 samples, decode the command.
    - addr ≥ NUM_REGS → IGNORE and pulse frame_err.
    - R/W=1 → RD; load the shift-out register with reg[addr].
    - R/W=0 → WR.
  - WR: each completed byte writes reg[addr] on the clk after the 8th sample edge, pulses wr_strobe with wr_addr=addr, then addr+1.
  - RD: MISO shifts out reg[addr]. When byte k is complete, reg[addr+1] is loaded before the next shift edge, so back-to-back reads stream with no gap.
  - IGNORE: MISO=0, no writes, until CS rises.
  - Any state: synchronised CS rising → IDLE.
    - Counter ≠ 0 in CMD/WR/RD → pulse frame_err; the partial byte is discarded and no write occurs.
    - A completed byte is never lost.
- MISO is 0 during the command byte and in IDLE/IGNORE. There is no tristate; top-level muxing is external.
- Read data is the register value at the moment of load. A write to the same address in an earlier byte of the frame is visible to a later read only in a later frame (single frame is one direction).
- Simultaneous events: a CS rise in the same clk as the 8th sample edge → the byte completes and is written first, then IDLE; no frame_err.
- CPOL/CPHA changes while CS is low are unsupported; the values latched at CS falling hold for the whole frame.
- Reset mid-frame: immediate return to reset state; the next frame requires a fresh CS falling edge.

Decomposition:
- Shared package spi_pkg: FSM state encoding (IDLE, CMD, WR, RD, IGNORE), CMD_RW_BIT=7, SYNC_STAGES=2.
- One sub-module, spi_pin_sync: 2-flop synchroniser plus rise/fall detect for sclk and CS, reused by the existing slave.
- The register bank and FSM live in spi_reg_slave.

Test Plan:
1. Single write, mode 0: CS low, MOSI bytes 8'h02, 8'hA5, CS high → reg[2]=A5; one wr_strobe with wr_addr=2; no frame_err.
2. Burst read with wrap, mode 3: preload reg[6]=11, reg[7]=22, reg[0]=33; send 8'h86 then 3 dummy bytes → master receives 00, 11, 22, 33.
3. All four CPOL/CPHA modes: write 8'h5A to reg[1], then read it back → master Rx = 5A in each mode; slave never writes other registers.
4. Abort mid-byte: 8'h03, then 4 bits of data, then CS high → reg[3] unchanged, frame_err single pulse, FSM=IDLE; the next frame works normally.
5. Bad address: command 8'h0F with NUM_REGS=8 → frame_err pulse; following data byte 8'hFF causes no write; MISO=0 throughout.
6. Async reset mid-burst: rst low during byte 2 of a write burst → all regs=00, MISO=0, no wr_strobe; after release, a new frame 8'h00, 8'h77 → reg[0]=77.
